// File: rtl/load_store_unit_if.sv
// Data-memory request/ready bus driven by the load/store unit.
// The unit is the master; a word-addressed data memory is the slave.
interface load_store_unit_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_ready_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        input  mem_ready_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        output mem_ready_i, mem_rdata_i
    );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store engine. It reads rs1/rs2 from the register
// bank, forms the effective address, performs one word-aligned memory access
// with byte strobes, then aligns/extends load data and writes it back to rd.
module load_store_unit (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     is_store_i,
    input  logic [2:0]               funct3_i,
    input  logic [4:0]               rs1_addr_i,
    input  logic [4:0]               rs2_addr_i,
    input  logic [4:0]               rd_addr_i,
    input  logic [11:0]              imm_i,
    output logic [4:0]               RS1_ADDR_o,
    output logic [4:0]               RS2_ADDR_o,
    input  logic [31:0]              RS1_data_i,
    input  logic [31:0]              RS2_data_i,
    output logic [4:0]               RD_ADDR_o,
    output logic [31:0]              data_o,
    output logic                     wr_en_o,
    load_store_unit_if.master        mem_bus,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);

    typedef enum logic [1:0] {IDLE, CALC, MEM, DONE} state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t      state;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [11:0] imm_q;
    logic [1:0]  off_q;

    logic [31:0] ea;
    logic        legal_f3;
    logic        misaligned;
    logic        calc_err;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] ld_shifted;
    logic [31:0] ld_value;

    // Address generation, legality check and store-lane formatting for CALC.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        legal_f3   = 1'b0;
        misaligned = 1'b0;
        st_wdata   = RS2_data_i;
        st_wstrb   = 4'b0000;

        ea = RS1_data_i + {{20{imm_q[11]}}, imm_q};

        if (is_store_q) begin
            legal_f3 = (funct3_q == F3_B) || (funct3_q == F3_H) || (funct3_q == F3_W);
        end else begin
            legal_f3 = (funct3_q == F3_B) || (funct3_q == F3_H) || (funct3_q == F3_W) ||
                       (funct3_q == F3_BU) || (funct3_q == F3_HU);
        end

        // Halfword accesses need ea[0]=0, word accesses need ea[1:0]=0.
        if (funct3_q[1:0] == 2'b01) begin
            misaligned = ea[0];
        end else if (funct3_q[1:0] == 2'b10) begin
            misaligned = (ea[1:0] != 2'b00);
        end

        if (is_store_q) begin
            case (funct3_q[1:0])
                2'b00: begin
                    st_wdata = {4{RS2_data_i[7:0]}};
                    st_wstrb = 4'b0001 << ea[1:0];
                end
                2'b01: begin
                    st_wdata = {2{RS2_data_i[15:0]}};
                    st_wstrb = 4'b0011 << ea[1:0];
                end
                default: begin
                    st_wdata = RS2_data_i;
                    st_wstrb = 4'b1111;
                end
            endcase
        end
    end

    assign calc_err = !legal_f3 || misaligned;

    // Load alignment: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        ld_shifted = mem_bus.mem_rdata_i >> {off_q, 3'b000};
        case (funct3_q)
            F3_B:    ld_value = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            F3_H:    ld_value = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            F3_BU:   ld_value = {24'd0, ld_shifted[7:0]};
            F3_HU:   ld_value = {16'd0, ld_shifted[15:0]};
            default: ld_value = ld_shifted;
        endcase
    end

    // Control FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            state                <= IDLE;
            is_store_q           <= 1'b0;
            funct3_q             <= 3'b000;
            imm_q                <= 12'd0;
            off_q                <= 2'b00;
            RS1_ADDR_o           <= 5'd0;
            RS2_ADDR_o           <= 5'd0;
            RD_ADDR_o            <= 5'd0;
            data_o               <= 32'd0;
            wr_en_o              <= 1'b0;
            mem_bus.mem_req_o    <= 1'b0;
            mem_bus.mem_we_o     <= 1'b0;
            mem_bus.mem_addr_o   <= 32'd0;
            mem_bus.mem_wdata_o  <= 32'd0;
            mem_bus.mem_wstrb_o  <= 4'b0000;
            busy_o               <= 1'b0;
            done_o               <= 1'b0;
            err_o                <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        is_store_q <= is_store_i;
                        funct3_q   <= funct3_i;
                        imm_q      <= imm_i;
                        RS1_ADDR_o <= rs1_addr_i;
                        RS2_ADDR_o <= rs2_addr_i;
                        RD_ADDR_o  <= rd_addr_i;
                        busy_o     <= 1'b1;
                        state      <= CALC;
                    end
                end

                CALC: begin
                    if (calc_err) begin
                        // Illegal or misaligned: report without touching memory.
                        done_o <= 1'b1;
                        err_o  <= 1'b1;
                        state  <= DONE;
                    end else begin
                        mem_bus.mem_addr_o  <= {ea[31:2], 2'b00};
                        mem_bus.mem_we_o    <= is_store_q;
                        mem_bus.mem_wdata_o <= is_store_q ? st_wdata : 32'd0;
                        mem_bus.mem_wstrb_o <= st_wstrb;
                        mem_bus.mem_req_o   <= 1'b1;
                        off_q               <= ea[1:0];
                        state               <= MEM;
                    end
                end

                MEM: begin
                    // Request fields stay frozen until the memory accepts.
                    if (mem_bus.mem_ready_i) begin
                        mem_bus.mem_req_o <= 1'b0;
                        mem_bus.mem_we_o  <= 1'b0;
                        done_o            <= 1'b1;
                        if (!is_store_q) begin
                            data_o  <= ld_value;
                            wr_en_o <= (RD_ADDR_o != 5'd0);
                        end
                        state <= DONE;
                    end
                end

                DONE: begin
                    done_o  <= 1'b0;
                    err_o   <= 1'b0;
                    wr_en_o <= 1'b0;
                    busy_o  <= 1'b0;
                    state   <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: register bank and data memory
// models, a vector table of loads/stores checked through a scoreboard, and
// hand-written sequences for wait states and mid-operation reset.
module tb_load_store_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_i;
    logic        is_store_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
    logic [11:0] imm_i;
    logic [4:0]  RS1_ADDR_o, RS2_ADDR_o, RD_ADDR_o;
    logic [31:0] RS1_data_i, RS2_data_i;
    logic [31:0] data_o;
    logic        wr_en_o, busy_o, done_o, err_o;

    load_store_unit_if mem_bus ();

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .is_store_i (is_store_i),
        .funct3_i   (funct3_i),
        .rs1_addr_i (rs1_addr_i),
        .rs2_addr_i (rs2_addr_i),
        .rd_addr_i  (rd_addr_i),
        .imm_i      (imm_i),
        .RS1_ADDR_o (RS1_ADDR_o),
        .RS2_ADDR_o (RS2_ADDR_o),
        .RS1_data_i (RS1_data_i),
        .RS2_data_i (RS2_data_i),
        .RD_ADDR_o  (RD_ADDR_o),
        .data_o     (data_o),
        .wr_en_o    (wr_en_o),
        .mem_bus    (mem_bus),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register bank model: asynchronous read, write at the clock edge.
    logic [31:0] regs [32];
    logic        pre_reg_we = 1'b0;
    logic [4:0]  pre_reg_addr = 5'd0;
    logic [31:0] pre_reg_data = 32'd0;

    always @(posedge clk) begin
        if (pre_reg_we) regs[pre_reg_addr] <= pre_reg_data;
        else if (wr_en_o && RD_ADDR_o != 5'd0) regs[RD_ADDR_o] <= data_o;
    end

    assign RS1_data_i = (RS1_ADDR_o == 5'd0) ? 32'd0 : regs[RS1_ADDR_o];
    assign RS2_data_i = (RS2_ADDR_o == 5'd0) ? 32'd0 : regs[RS2_ADDR_o];

    // Word-addressed data memory model with byte strobes.
    logic [31:0] mem_words [256];
    logic        pre_mem_we = 1'b0;
    logic [7:0]  pre_mem_idx = 8'd0;
    logic [31:0] pre_mem_data = 32'd0;
    logic        mem_ready = 1'b1;

    always @(posedge clk) begin
        if (pre_mem_we) mem_words[pre_mem_idx] <= pre_mem_data;
        else if (mem_bus.mem_req_o && mem_bus.mem_ready_i && mem_bus.mem_we_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_bus.mem_wstrb_o[b])
                    mem_words[mem_bus.mem_addr_o[9:2]][8*b +: 8] <= mem_bus.mem_wdata_o[8*b +: 8];
        end
    end

    assign mem_bus.mem_ready_i = mem_ready;
    assign mem_bus.mem_rdata_i = mem_words[mem_bus.mem_addr_o[9:2]];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_store;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [11:0] imm;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic        exp_err;
        logic        exp_wr;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        vec_t v;
        int   accept_cyc;
        int   exp_lat;
    } sb_t;

    sb_t  sb_q[$];
    sb_t  mon_e;
    logic saw_req = 1'b0;

    // Monitor: compare memory requests and completions against the scoreboard head.
    always @(negedge clk) begin
        if (rst) begin
            saw_req = 1'b0;
        end else begin
            if (mem_bus.mem_req_o && mem_bus.mem_ready_i) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_mem_req", 32'd1, 32'd0);
                end else begin
                    check("mem_addr", mem_bus.mem_addr_o, sb_q[0].v.exp_addr);
                    check("mem_we", 32'(mem_bus.mem_we_o), 32'(sb_q[0].v.is_store));
                    check("mem_wstrb", 32'(mem_bus.mem_wstrb_o), 32'(sb_q[0].v.exp_wstrb));
                    if (sb_q[0].v.is_store)
                        check("mem_wdata", mem_bus.mem_wdata_o, sb_q[0].v.exp_wdata);
                    saw_req = 1'b1;
                end
            end
            if (done_o) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("err_o", 32'(err_o), 32'(mon_e.v.exp_err));
                    check("wr_en_o", 32'(wr_en_o), 32'(mon_e.v.exp_wr));
                    check("rd_addr", 32'(RD_ADDR_o), 32'(mon_e.v.rd));
                    check("latency", 32'(cyc - mon_e.accept_cyc), 32'(mon_e.exp_lat));
                    check("mem_access", 32'(saw_req), 32'(!mon_e.v.exp_err));
                    if (mon_e.v.exp_wr)
                        check("data_o", data_o, mon_e.v.exp_data);
                end
                saw_req = 1'b0;
            end
        end
    end

    task automatic preload_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_reg_we = 1'b1; pre_reg_addr = a; pre_reg_data = d;
        @(negedge clk);
        pre_reg_we = 1'b0;
    endtask

    task automatic preload_mem(input logic [31:0] byte_addr, input logic [31:0] d);
        @(negedge clk);
        pre_mem_we = 1'b1; pre_mem_idx = byte_addr[9:2]; pre_mem_data = d;
        @(negedge clk);
        pre_mem_we = 1'b0;
    endtask

    // Present one operation in IDLE, then queue its expected results.
    task automatic issue(input vec_t v, input int exp_lat);
        sb_t e;
        @(negedge clk);
        start_i    = 1'b1;
        is_store_i = v.is_store;
        funct3_i   = v.funct3;
        rs1_addr_i = v.rs1;
        rs2_addr_i = v.rs2;
        rd_addr_i  = v.rd;
        imm_i      = v.imm;
        @(posedge clk);
        #1;
        start_i      = 1'b0;
        e.v          = v;
        e.accept_cyc = cyc - 1;
        e.exp_lat    = exp_lat;
        sb_q.push_back(e);
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("done_timeout", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    vec_t vecs[22];
    vec_t v_ws;

    initial begin
        rst = 1'b1; start_i = 1'b0; is_store_i = 1'b0; funct3_i = 3'b000;
        rs1_addr_i = 5'd0; rs2_addr_i = 5'd0; rd_addr_i = 5'd0; imm_i = 12'd0;

        //            st    f3      rs1   rs2   rd     imm      addr           wdata          strb     err   wr    data
        vecs[0]  = '{1'b0, 3'b010, 5'd1, 5'd0, 5'd5,  12'h004, 32'h0000_1004, 32'h0,         4'b0000, 1'b0, 1'b1, 32'h8123_45F6};
        vecs[1]  = '{1'b0, 3'b000, 5'd1, 5'd0, 5'd6,  12'h007, 32'h0000_1004, 32'h0,         4'b0000, 1'b0, 1'b1, 32'hFFFF_FF81};
        vecs[2]  = '{1'b0, 3'b100, 5'd1, 5'd0, 5'd7,  12'h007, 32'h0000_1004, 32'h0,         4'b0000, 1'b0, 1'b1, 32'h0000_0081};
        vecs[3]  = '{1'b0, 3'b001, 5'd1, 5'd0, 5'd8,  12'h006, 32'h0000_1004, 32'h0,         4'b0000, 1'b0, 1'b1, 32'hFFFF_8123};
        vecs[4]  = '{1'b0, 3'b101, 5'd1, 5'd0, 5'd9,  12'h004, 32'h0000_1004, 32'h0,         4'b0000, 1'b0, 1'b1, 32'h0000_45F6};
        vecs[5]  = '{1'b0, 3'b000, 5'd1, 5'd0, 5'd10, 12'h004, 32'h0000_1004, 32'h0,         4'b0000, 1'b0, 1'b1, 32'hFFFF_FFF6};
        vecs[6]  = '{1'b1, 3'b000, 5'd1, 5'd2, 5'd0,  12'h002, 32'h0000_1000, 32'hABAB_ABAB, 4'b0100, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 3'b010, 5'd1, 5'd0, 5'd11, 12'h000, 32'h0000_1000, 32'h0,         4'b0000, 1'b0, 1'b1, 32'h00AB_0000};
        vecs[8]  = '{1'b1, 3'b010, 5'd1, 5'd3, 5'd0,  12'hFFC, 32'h0000_0FFC, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 3'b010, 5'd1, 5'd0, 5'd12, 12'hFFC, 32'h0000_0FFC, 32'h0,         4'b0000, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[10] = '{1'b1, 3'b001, 5'd1, 5'd4, 5'd0,  12'h006, 32'h0000_1004, 32'h1234_1234, 4'b1100, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 3'b010, 5'd1, 5'd0, 5'd13, 12'h004, 32'h0000_1004, 32'h0,         4'b0000, 1'b0, 1'b1, 32'h1234_45F6};
        vecs[12] = '{1'b0, 3'b010, 5'd1, 5'd0, 5'd0,  12'h004, 32'h0000_1004, 32'h0,         4'b0000, 1'b0, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 3'b010, 5'd1, 5'd0, 5'd15, 12'h008, 32'h0000_1008, 32'h0,         4'b0000, 1'b0, 1'b1, 32'h0000_1000};
        vecs[14] = '{1'b0, 3'b010, 5'd15,5'd0, 5'd16, 12'h004, 32'h0000_1004, 32'h0,         4'b0000, 1'b0, 1'b1, 32'h1234_45F6};
        vecs[15] = '{1'b0, 3'b010, 5'd1, 5'd0, 5'd17, 12'h002, 32'h0,         32'h0,         4'b0000, 1'b1, 1'b0, 32'h0};
        vecs[16] = '{1'b1, 3'b001, 5'd1, 5'd4, 5'd0,  12'h001, 32'h0,         32'h0,         4'b0000, 1'b1, 1'b0, 32'h0};
        vecs[17] = '{1'b0, 3'b011, 5'd1, 5'd0, 5'd17, 12'h004, 32'h0,         32'h0,         4'b0000, 1'b1, 1'b0, 32'h0};
        vecs[18] = '{1'b0, 3'b110, 5'd1, 5'd0, 5'd17, 12'h004, 32'h0,         32'h0,         4'b0000, 1'b1, 1'b0, 32'h0};
        vecs[19] = '{1'b1, 3'b100, 5'd1, 5'd2, 5'd0,  12'h004, 32'h0,         32'h0,         4'b0000, 1'b1, 1'b0, 32'h0};
        vecs[20] = '{1'b0, 3'b001, 5'd1, 5'd0, 5'd18, 12'h001, 32'h0,         32'h0,         4'b0000, 1'b1, 1'b0, 32'h0};
        vecs[21] = '{1'b0, 3'b101, 5'd1, 5'd0, 5'd19, 12'h002, 32'h0000_1000, 32'h0,         4'b0000, 1'b0, 1'b1, 32'h0000_00AB};
        v_ws     = '{1'b0, 3'b010, 5'd1, 5'd0, 5'd20, 12'h004, 32'h0000_1004, 32'h0,         4'b0000, 1'b0, 1'b1, 32'h1234_45F6};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", 32'({busy_o, done_o, err_o, wr_en_o, mem_bus.mem_req_o, mem_bus.mem_we_o}), 32'd0);
        check("rst_reg_addrs", 32'({RS1_ADDR_o, RS2_ADDR_o, RD_ADDR_o}), 32'd0);
        check("rst_mem_addr", mem_bus.mem_addr_o, 32'd0);
        check("rst_mem_wdata", mem_bus.mem_wdata_o, 32'd0);
        check("rst_mem_wstrb", 32'(mem_bus.mem_wstrb_o), 32'd0);
        check("rst_data_o", data_o, 32'd0);
        rst = 1'b0;

        preload_reg(5'd1,  32'h0000_1000);
        preload_reg(5'd2,  32'h0000_00AB);
        preload_reg(5'd3,  32'hDEAD_BEEF);
        preload_reg(5'd4,  32'h0000_1234);
        preload_reg(5'd21, 32'h5555_AAAA);
        preload_mem(32'h0000_1000, 32'h0000_0000);
        preload_mem(32'h0000_1004, 32'h8123_45F6);
        preload_mem(32'h0000_1008, 32'h0000_1000);
        preload_mem(32'h0000_0FFC, 32'h0000_0000);

        // Vector table, zero wait states.
        for (int i = 0; i < 22; i++) begin
            issue(vecs[i], vecs[i].exp_err ? 2 : 3);
            wait_done();
        end
        @(negedge clk);
        check("bank_x5", regs[5], 32'h8123_45F6);
        check("bank_x16", regs[16], 32'h1234_45F6);
        check("mem_after_sw", mem_words[8'hFF], 32'hDEAD_BEEF);

        // Wait states: ready low for five request cycles, stray starts meanwhile.
        mem_ready = 1'b0;
        issue(v_ws, 8);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("ws_req", 32'(mem_bus.mem_req_o), 32'd1);
            check("ws_addr", mem_bus.mem_addr_o, 32'h0000_1004);
            check("ws_we_strb", 32'({mem_bus.mem_we_o, mem_bus.mem_wstrb_o}), 32'd0);
            start_i = 1'b1; is_store_i = 1'b1; funct3_i = 3'b000;
            rd_addr_i = 5'd21; rs1_addr_i = 5'd2; imm_i = 12'h003;
        end
        @(negedge clk);
        start_i   = 1'b0;
        mem_ready = 1'b1;
        wait_done();
        @(negedge clk);
        check("ws_idle_busy", 32'(busy_o), 32'd0);
        check("bank_x20", regs[20], 32'h1234_45F6);

        // Reset while waiting in MEM abandons the request without write-back.
        v_ws.rd   = 5'd21;
        mem_ready = 1'b0;
        issue(v_ws, 3);
        @(negedge clk);
        @(negedge clk);
        check("rstm_req_before", 32'(mem_bus.mem_req_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rstm_ctrl", 32'({busy_o, done_o, err_o, wr_en_o, mem_bus.mem_req_o}), 32'd0);
        sb_q.delete();
        rst       = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        check("rstm_no_writeback", regs[21], 32'h5555_AAAA);
        issue(v_ws, 3);
        wait_done();
        @(negedge clk);
        check("rstm_after_lw", regs[21], 32'h1234_45F6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
